multdiv_unit: RTL and testbench

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_pkg.sv | 17 +
 rtl/multdiv_counter.sv | 28 ++
 rtl/multdiv_unit.sv | 159 +++++++++++++++
 tb/tb_multdiv_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared constants for the sequential multiply/divide unit: default width,
// FSM state encoding and operation-type encoding.
package multdiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: counts enabled cycles from zero; tc flags the last
// iteration (count == LAST).
module multdiv_counter #(
  parameter int LAST = 31,
  parameter int CW   = 6
) (
  input  logic clk,
  input  logic clr_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(LAST));

endmodule

// File: rtl/multdiv_unit.sv
// Sequential signed multiply/divide: one radix-2 step per cycle on operand
// magnitudes, sign and exception fix-up applied in the DONE cycle.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a start pulse
// MUL     | shift-add multiply step each cycle, WIDTH steps
// DIV     | restoring divide step each cycle, WIDTH steps
// DONE    | sign/exception fix-up, result + one-cycle strobe registered
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state, state_nxt;
  logic             start, op_load, iter_en, res_load, tc;
  op_e              op_q;
  logic             neg_q, dz_q, ovf_q;
  logic [WIDTH-1:0] a_mag, b_mag, b_q;
  logic [WIDTH-1:0] hi_q, lo_q, hi_nxt, lo_nxt;
  logic [WIDTH:0]   msum, dshift;
  logic [WIDTH-1:0] ddiff;
  logic             ge;
  logic [2*WIDTH-1:0] prod, sprod;
  logic [WIDTH-1:0] quot, res_nxt;
  logic             exc_nxt, mexc;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign op_load  = start;
  assign iter_en  = ((state == ST_MUL) || (state == ST_DIV)) && !start;
  assign res_load = (state == ST_DONE) && !start;

  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  multdiv_counter #(
    .LAST(WIDTH - 1),
    .CW  (CW)
  ) u_cnt (
    .clk  (clk),
    .clr_n(clr_n),
    .en   (iter_en),
    .clr  (start),
    .tc   (tc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_MUL, ST_DIV: if (tc) state_nxt = ST_DONE;
      ST_DONE:        state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
    if (ctrl_MULT)     state_nxt = ST_MUL;
    else if (ctrl_DIV) state_nxt = ST_DIV;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // hi:lo is the product in MUL; hi is the partial remainder and lo the
  // dividend shifting out / quotient shifting in during DIV.
  assign msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign dshift = {hi_q, lo_q[WIDTH-1]};
  assign ge     = (dshift >= {1'b0, b_q});
  assign ddiff  = dshift[WIDTH-1:0] - b_q;

  always_comb begin
    hi_nxt = hi_q;
    lo_nxt = lo_q;
    if (state == ST_MUL) begin
      hi_nxt = msum[WIDTH:1];
      lo_nxt = {msum[0], lo_q[WIDTH-1:1]};
    end else if (state == ST_DIV) begin
      hi_nxt = ge ? ddiff : dshift[WIDTH-1:0];
      lo_nxt = {lo_q[WIDTH-2:0], ge};
    end
  end

  assign prod  = {hi_q, lo_q};
  assign sprod = neg_q ? -prod : prod;
  assign mexc  = !((&sprod[2*WIDTH-1:WIDTH-1]) || !(|sprod[2*WIDTH-1:WIDTH-1]));
  assign quot  = neg_q ? -lo_q : lo_q;

  always_comb begin
    res_nxt = quot;
    exc_nxt = 1'b0;
    if (op_q == OP_MUL) begin
      res_nxt = sprod[WIDTH-1:0];
      exc_nxt = mexc;
    end else if (dz_q) begin
      res_nxt = '0;
      exc_nxt = 1'b1;
    end else if (ovf_q) begin
      exc_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      op_q  <= OP_MUL;
      b_q   <= '0;
      neg_q <= 1'b0;
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (op_load) begin
      op_q  <= ctrl_MULT ? OP_MUL : OP_DIV;
      b_q   <= b_mag;
      neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz_q  <= (data_operandB == '0);
      ovf_q <= (data_operandA == MIN_NEG) && (data_operandB == '1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (op_load) begin
      hi_q <= '0;
      lo_q <= a_mag;
    end else if (iter_en) begin
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (res_load) begin
      data_result    <= res_nxt;
      data_exception <= exc_nxt;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) data_resultRDY <= 1'b0;
    else        data_resultRDY <= res_load;
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed cases plus randomized operations checked
// against a plain-arithmetic reference model.
module tb_multdiv_unit;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks = 0;
  int errors = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .clr_n         (clr_n),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
    longint      p;
    logic [63:0] pu;
    if (mul) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      pu = p;
      r  = pu[31:0];
      e  = !((pu[63:31] == '0) || (pu[63:31] == '1));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: v = $urandom_range(0, 300);
      6: v = -$urandom_range(1, 300);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Presents a start on the next rising edge, then scrambles the operand
  // inputs so that only the captured values can matter.
  task automatic start_op(input bit mul, input bit both, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ctrl_MULT     = mul | both;
    ctrl_DIV      = !mul | both;
    data_operandA = a;
    data_operandB = b;
    @(negedge clk);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp_r, input logic exp_e);
    int          n = 0;
    int          at = -1;
    logic [31:0] r = '0;
    logic        e = 1'b0;
    // first posedge seen here is edge 1 after the start edge
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(posedge clk);
      else       @(posedge clk);
      #1;
      if (data_resultRDY) begin
        n++;
        if (n == 1) begin
          at = k;
          r  = data_result;
          e  = data_exception;
        end
      end
    end
    chk({tag, "_rdy_count"}, 64'(n), 64'd1);
    chk({tag, "_rdy_cycle"}, 64'(at), 64'd33);
    chk({tag, "_result"}, 64'(r), 64'(exp_r));
    chk({tag, "_exc"}, 64'(e), 64'(exp_e));
    chk({tag, "_hold"}, 64'(data_result), 64'(exp_r));
  endtask

  task automatic run_ref(input string tag, input bit mul, input bit both,
                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    ref_model(mul | both, a, b, r, e);
    start_op(mul, both, a, b);
    wait_done(tag, r, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr;
    #1;
    chk("reset_result", 64'(data_result), 64'd0);
    chk("reset_exc", 64'(data_exception), 64'd0);
    chk("reset_rdy", 64'(data_resultRDY), 64'd0);
    repeat (3) @(negedge clk);
    clr_n = 1'b1;

    start_op(1'b1, 1'b0, 32'd7, -32'sd3);
    wait_done("mul_7x-3", 32'hFFFF_FFEB, 1'b0);
    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_done("mul_ovf", 32'h0000_0000, 1'b1);
    start_op(1'b0, 1'b0, -32'sd17, 32'd5);
    wait_done("div_-17/5", 32'hFFFF_FFFD, 1'b0);
    start_op(1'b0, 1'b0, 32'd100, 32'd0);
    wait_done("div_by_zero", 32'd0, 1'b1);
    start_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_min/-1", 32'h8000_0000, 1'b1);
    start_op(1'b0, 1'b1, 32'd9, 32'd4);
    wait_done("both_starts", 32'd36, 1'b0);

    // abort: MULT restarted as DIV on its 10th edge
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    nr = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (data_resultRDY) nr++;
    end
    start_op(1'b0, 1'b0, 32'd100, 32'd7);
    chk("abort_early_rdy", 64'(nr), 64'd0);
    wait_done("abort_div", 32'd14, 1'b0);

    // reset in the middle of a multiply
    start_op(1'b1, 1'b0, 32'd123, 32'd456);
    repeat (13) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk("midrst_result", 64'(data_result), 64'd0);
    chk("midrst_exc", 64'(data_exception), 64'd0);
    chk("midrst_rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    nr = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (data_resultRDY) nr++;
    end
    chk("midrst_no_rdy", 64'(nr), 64'd0);
    start_op(1'b1, 1'b0, 32'd2, 32'd3);
    wait_done("after_rst", 32'd6, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      bit          mul;
      bit          both;
      a    = pick_operand();
      b    = pick_operand();
      mul  = 1'($urandom_range(0, 1));
      both = ($urandom_range(0, 9) == 0);
      run_ref($sformatf("rnd%0d", i), mul, both, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
